// File: rtl/axil_arm_bridge.sv
// ---------------------------------------------------------------------------
// axil_arm_bridge
//   AXI4-Lite slave that turns each read or write into one level-held
//   armreq/armack transaction toward a register-block responder. Only one
//   transaction is ever in flight. If the responder does not answer within
//   TIMEOUT cycles, the request is abandoned and DECERR is returned. An
//   acknowledge carrying armerr returns SLVERR.
//
// Ports
//   clk, rstn                   clock, asynchronous active-low reset
//   aw*/w*/b*                   AXI-Lite write address, data and response
//   ar*/r*                      AXI-Lite read address and data
//   armaddr/armwdata/armwstrb   request payload, held between requests
//   armwr                       1 = write request, 0 = read request
//   armreq                      request level, high until ack or timeout
//   armack/armrdata/armerr      responder answer, valid in the ack cycle
// ---------------------------------------------------------------------------
module axil_arm_bridge #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [31:0] awaddr,
   input  logic        awvalid,
   output logic        awready,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   input  logic        wvalid,
   output logic        wready,
   output logic [1:0]  bresp,
   output logic        bvalid,
   input  logic        bready,
   input  logic [31:0] araddr,
   input  logic        arvalid,
   output logic        arready,
   output logic [31:0] rdata,
   output logic [1:0]  rresp,
   output logic        rvalid,
   input  logic        rready,
   output logic [31:0] armaddr,
   output logic [31:0] armwdata,
   output logic [3:0]  armwstrb,
   output logic        armwr,
   output logic        armreq,
   input  logic        armack,
   input  logic [31:0] armrdata,
   input  logic        armerr
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      WRESP = 2'd2,
      RRESP = 2'd3
   } state_t;

   localparam int            CW       = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   state_t        state_q,     state_d;
   logic [CW-1:0] cnt_q,       cnt_d;
   logic          prefer_rd_q, prefer_rd_d;
   logic          accept_en_q, accept_en_d;
   logic [31:0]   armaddr_q,   armaddr_d;
   logic [31:0]   armwdata_q,  armwdata_d;
   logic [3:0]    armwstrb_q,  armwstrb_d;
   logic          armwr_q,     armwr_d;
   logic          armreq_q,    armreq_d;
   logic          bvalid_q,    bvalid_d;
   logic [1:0]    bresp_q,     bresp_d;
   logic          rvalid_q,    rvalid_d;
   logic [1:0]    rresp_q,     rresp_d;
   logic [31:0]   rdata_q,     rdata_d;

   logic          wr_elig;
   logic          rd_elig;
   logic          take_wr;
   logic          take_rd;

   // A write needs both AW and W present; neither channel is accepted alone.
   // accept_en_q keeps all readies low while reset is asserted and for the
   // first cycle after release, so the readies are 0 during reset even though
   // they are decoded from live valids.
   assign wr_elig = awvalid & wvalid;
   assign rd_elig = arvalid;
   assign take_wr = (state_q == IDLE) & accept_en_q & wr_elig & (~rd_elig | ~prefer_rd_q);
   assign take_rd = (state_q == IDLE) & accept_en_q & rd_elig & (~wr_elig |  prefer_rd_q);

   assign awready  = take_wr;
   assign wready   = take_wr;
   assign arready  = take_rd;

   assign armaddr  = armaddr_q;
   assign armwdata = armwdata_q;
   assign armwstrb = armwstrb_q;
   assign armwr    = armwr_q;
   assign armreq   = armreq_q;
   assign bvalid   = bvalid_q;
   assign bresp    = bresp_q;
   assign rvalid   = rvalid_q;
   assign rresp    = rresp_q;
   assign rdata    = rdata_q;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      prefer_rd_d = prefer_rd_q;
      accept_en_d = 1'b1;
      armaddr_d   = armaddr_q;
      armwdata_d  = armwdata_q;
      armwstrb_d  = armwstrb_q;
      armwr_d     = armwr_q;
      armreq_d    = armreq_q;
      bvalid_d    = bvalid_q;
      bresp_d     = bresp_q;
      rvalid_d    = rvalid_q;
      rresp_d     = rresp_q;
      rdata_d     = rdata_q;

      case (state_q)
         IDLE: begin
            if (take_wr) begin
               armaddr_d   = awaddr;
               armwdata_d  = wdata;
               armwstrb_d  = wstrb;
               armwr_d     = 1'b1;
               armreq_d    = 1'b1;
               cnt_d       = '0;
               prefer_rd_d = 1'b1;   // next tie goes to the read side
               state_d     = REQ;
            end else if (take_rd) begin
               armaddr_d   = araddr;
               armwdata_d  = 32'h0;
               armwstrb_d  = 4'h0;
               armwr_d     = 1'b0;
               armreq_d    = 1'b1;
               cnt_d       = '0;
               prefer_rd_d = 1'b0;
               state_d     = REQ;
            end
         end

         REQ: begin
            cnt_d = cnt_q + CNT_ONE;
            // Ack is tested first so it wins over a timeout in the same cycle.
            if (armack) begin
               armreq_d = 1'b0;
               cnt_d    = '0;
               if (armwr_q) begin
                  bvalid_d = 1'b1;
                  bresp_d  = armerr ? RESP_SLVERR : RESP_OKAY;
                  state_d  = WRESP;
               end else begin
                  rvalid_d = 1'b1;
                  rresp_d  = armerr ? RESP_SLVERR : RESP_OKAY;
                  rdata_d  = armrdata;
                  state_d  = RRESP;
               end
            end else if (cnt_q == CNT_LAST) begin
               // cnt_q counts REQ cycles from 0, so armreq was high exactly
               // TIMEOUT cycles when this branch fires.
               armreq_d = 1'b0;
               cnt_d    = '0;
               if (armwr_q) begin
                  bvalid_d = 1'b1;
                  bresp_d  = RESP_DECERR;
                  state_d  = WRESP;
               end else begin
                  rvalid_d = 1'b1;
                  rresp_d  = RESP_DECERR;
                  rdata_d  = 32'h0;
                  state_d  = RRESP;
               end
            end
         end

         // armreq stays low here and in the following IDLE cycle, which gives
         // the responder's edge detector the low cycle it needs.
         WRESP: begin
            if (bready) begin
               bvalid_d = 1'b0;
               state_d  = IDLE;
            end
         end

         RRESP: begin
            if (rready) begin
               rvalid_d = 1'b0;
               state_d  = IDLE;
            end
         end

         default: begin
            state_d  = IDLE;
            armreq_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         prefer_rd_q <= 1'b0;
         accept_en_q <= 1'b0;
         armaddr_q   <= 32'h0;
         armwdata_q  <= 32'h0;
         armwstrb_q  <= 4'h0;
         armwr_q     <= 1'b0;
         armreq_q    <= 1'b0;
         bvalid_q    <= 1'b0;
         bresp_q     <= 2'b00;
         rvalid_q    <= 1'b0;
         rresp_q     <= 2'b00;
         rdata_q     <= 32'h0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         prefer_rd_q <= prefer_rd_d;
         accept_en_q <= accept_en_d;
         armaddr_q   <= armaddr_d;
         armwdata_q  <= armwdata_d;
         armwstrb_q  <= armwstrb_d;
         armwr_q     <= armwr_d;
         armreq_q    <= armreq_d;
         bvalid_q    <= bvalid_d;
         bresp_q     <= bresp_d;
         rvalid_q    <= rvalid_d;
         rresp_q     <= rresp_d;
         rdata_q     <= rdata_d;
      end
   end

endmodule

// File: tb/tb_axil_arm_bridge.sv
// ---------------------------------------------------------------------------
// tb_axil_arm_bridge
//   Bench for axil_arm_bridge (TIMEOUT = 16). A behavioural responder answers
//   armreq after a programmable delay from a 16-word register file; address
//   bit 9 selects "never acks", bit 8 selects "acks with armerr". Directed
//   vectors come from a table, corner cases from hand sequences, and random
//   traffic is compared against a transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_axil_arm_bridge;

   localparam int TO = 16;

   logic        clk;
   logic        rstn;
   logic [31:0] awaddr;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;
   logic [31:0] araddr;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;
   logic [31:0] armaddr;
   logic [31:0] armwdata;
   logic [3:0]  armwstrb;
   logic        armwr;
   logic        armreq;
   logic        armack;
   logic [31:0] armrdata;
   logic        armerr;

   axil_arm_bridge #(.TIMEOUT(TO)) dut (
      .clk(clk), .rstn(rstn),
      .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
      .armaddr(armaddr), .armwdata(armwdata), .armwstrb(armwstrb),
      .armwr(armwr), .armreq(armreq), .armack(armack),
      .armrdata(armrdata), .armerr(armerr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   // responder state
   logic [31:0] resp_mem [16];
   int          ack_dly   = 1;
   bit          force_ack = 1'b0;
   bit          busy      = 1'b0;
   int          rcnt      = 0;

   // reference model state
   logic [31:0] model_mem [16];

   // monitor state
   int          req_starts = 0;
   int          cur_len    = 0;
   int          last_len   = 0;
   bit          req_prev   = 1'b0;
   int          n_bhs      = 0;
   int          n_rhs      = 0;
   int          overlap    = 0;
   logic [31:0] mon_addr   = 32'h0;
   logic [31:0] mon_wdata  = 32'h0;
   logic [3:0]  mon_strb   = 4'h0;
   logic        mon_wr     = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Responder: acks ack_dly cycles after armreq is first seen high.
   initial begin
      armack   = 1'b0;
      armerr   = 1'b0;
      armrdata = 32'h0;
      forever begin
         @(posedge clk);
         #1;
         armack   = 1'b0;
         armerr   = 1'b0;
         armrdata = 32'h0;
         if (!armreq) begin
            busy = 1'b0;
         end else if (!busy) begin
            busy = 1'b1;
            rcnt = 0;
         end else begin
            rcnt++;
         end
         if (armreq && busy && rcnt == ack_dly && !armaddr[9]) begin
            armack   = 1'b1;
            armerr   = armaddr[8];
            if (armwr && !armaddr[8]) begin
               for (int b = 0; b < 4; b++)
                  if (armwstrb[b]) resp_mem[armaddr[5:2]][8*b +: 8] = armwdata[8*b +: 8];
            end
            armrdata = resp_mem[armaddr[5:2]];
         end
         if (force_ack) begin
            armack   = 1'b1;
            armerr   = 1'b1;
            armrdata = 32'hBAD0_BAD0;
         end
      end
   end

   // Monitor: request starts/lengths, payload at request start, response handshakes.
   always @(negedge clk) begin
      if (armreq && !req_prev) begin
         req_starts++;
         mon_addr  = armaddr;
         mon_wdata = armwdata;
         mon_strb  = armwstrb;
         mon_wr    = armwr;
      end
      if (armreq) cur_len++;
      else if (cur_len != 0) begin
         last_len = cur_len;
         cur_len  = 0;
      end
      if (armreq && (bvalid || rvalid)) overlap++;
      if (bvalid && bready) n_bhs++;
      if (rvalid && rready) n_rhs++;
      req_prev = armreq;
   end

   // Reference model: outcome of one transaction from the responder's address
   // map and the bridge's response/latency rules.
   task automatic model_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [3:0] strb, input int dly,
                            output logic [1:0] resp, output logic [31:0] rd, output int lat);
      logic [3:0] idx;
      idx = addr[5:2];
      if (addr[9]) begin
         resp = 2'b11;
         rd   = 32'h0;
         lat  = TO + 1;
      end else begin
         lat = dly + 2;
         if (addr[8]) begin
            resp = 2'b10;
         end else begin
            resp = 2'b00;
            if (wr)
               for (int b = 0; b < 4; b++)
                  if (strb[b]) model_mem[idx][8*b +: 8] = wd[8*b +: 8];
         end
         rd = model_mem[idx];
      end
   endtask

   // One AXI transaction. lat = cycles from the handshake cycle to the first
   // cycle with bvalid/rvalid. The response handshake completes only if the
   // corresponding ready is high.
   task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] strb,
                          output logic [1:0] resp, output logic [31:0] rd, output int lat);
      int n;
      resp = 2'b00;
      rd   = 32'h0;
      lat  = -1;
      @(posedge clk);
      #1;
      if (wr) begin
         awaddr = addr; wdata = wd; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
      end else begin
         araddr = addr; arvalid = 1'b1;
      end
      n = 0;
      forever begin
         @(negedge clk);
         if (wr ? (awready && wready) : arready) break;
         n++;
         if (n > 50) break;
      end
      if (n > 50) begin
         chk("handshake_wait", 32'(n), 32'd0);
         awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
         return;
      end
      chk("aw_w_ready_pair", {30'd0, awready, wready}, wr ? 32'd3 : 32'd0);
      @(posedge clk);
      #1;
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      for (int c = 1; c < 200; c++) begin
         @(negedge clk);
         if (wr ? bvalid : rvalid) begin
            lat  = c;
            resp = wr ? bresp : rresp;
            rd   = rdata;
            break;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2;
      rstn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1;
   endtask

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [3:0]  strb;
      int          dly;
      logic [1:0]  exp_resp;
      logic [31:0] exp_rd;
      int          exp_lat;
   } vec_t;

   vec_t tbl [10];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got running expected finished");
      $fatal(1);
   end

   initial begin
      logic [1:0]  resp, eresp;
      logic [31:0] rd, erd, v;
      int          lat, elat, n, s0, b0, r0;
      bit          wr, got_wr;
      logic [31:0] addr;

      tbl[0] = '{1'b1, 32'h0000_0010, 32'h1234_5678, 4'hF, 1, 2'b00, 32'h0,         3};
      tbl[1] = '{1'b0, 32'h0000_000C, 32'h0,         4'h0, 1, 2'b00, 32'h0000_0004, 3};
      tbl[2] = '{1'b0, 32'h0000_010C, 32'h0,         4'h0, 1, 2'b10, 32'h0000_0004, 3};
      tbl[3] = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 1, 2'b00, 32'h1234_5678, 3};
      tbl[4] = '{1'b1, 32'h0000_0010, 32'hAABB_CCDD, 4'h5, 2, 2'b00, 32'h0,         4};
      tbl[5] = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 1, 2'b00, 32'h12BB_56DD, 3};
      tbl[6] = '{1'b1, 32'h0000_0104, 32'hFFFF_FFFF, 4'hF, 1, 2'b10, 32'h0,         3};
      tbl[7] = '{1'b0, 32'h0000_0200, 32'h0,         4'h0, 1, 2'b11, 32'h0,         TO + 1};
      tbl[8] = '{1'b1, 32'h0000_0204, 32'h0000_0001, 4'hF, 1, 2'b11, 32'h0,         TO + 1};
      tbl[9] = '{1'b0, 32'h0000_0004, 32'h0,         4'h0, 3, 2'b00, 32'h0,         5};

      rstn = 1'b0;
      awaddr = 32'h0; awvalid = 1'b0; wdata = 32'h0; wstrb = 4'h0; wvalid = 1'b0;
      araddr = 32'h0; arvalid = 1'b0; bready = 1'b1; rready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         resp_mem[i]  = 32'h0;
         model_mem[i] = 32'h0;
      end
      resp_mem[3] = 32'h0000_0004;

      // reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_ctrl", {22'd0, awready, wready, arready, bvalid, rvalid, armreq, armwr, armwstrb[0], bresp, rresp}, 32'd0);
      chk("reset_armaddr", armaddr, 32'h0);
      chk("reset_armwdata", armwdata, 32'h0);
      chk("reset_rdata", rdata | {28'd0, armwstrb}, 32'h0);
      @(posedge clk);
      #1;
      rstn = 1'b1;

      // directed table
      for (int i = 0; i < 10; i++) begin
         ack_dly = tbl[i].dly;
         run_txn(tbl[i].wr, tbl[i].addr, tbl[i].wd, tbl[i].strb, resp, rd, lat);
         chk($sformatf("tbl%0d_resp", i), {30'd0, resp}, {30'd0, tbl[i].exp_resp});
         chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'(tbl[i].exp_lat));
         if (!tbl[i].wr) chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
         chk($sformatf("tbl%0d_armaddr", i), mon_addr, tbl[i].addr);
         chk($sformatf("tbl%0d_armwr", i), {31'd0, mon_wr}, {31'd0, tbl[i].wr});
         chk($sformatf("tbl%0d_armwdata", i), mon_wdata, tbl[i].wr ? tbl[i].wd : 32'h0);
         chk($sformatf("tbl%0d_armwstrb", i), {28'd0, mon_strb}, {28'd0, tbl[i].wr ? tbl[i].strb : 4'h0});
      end

      // timeout with response held, then a late ack while waiting and in IDLE
      rready  = 1'b0;
      ack_dly = 1;
      run_txn(1'b0, 32'h0000_0208, 32'h0, 4'h0, resp, rd, lat);
      chk("to_resp", {30'd0, resp}, 32'd3);
      chk("to_rdata", rd, 32'h0);
      chk("to_lat", 32'(lat), 32'(TO + 1));
      @(negedge clk);
      force_ack = 1'b1;
      @(negedge clk);
      force_ack = 1'b0;
      @(negedge clk);
      chk("late_ack_rvalid_rresp", {29'd0, rvalid, rresp}, 32'd7);
      chk("late_ack_rdata", rdata, 32'h0);
      rready = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("to_rvalid_drop", {31'd0, rvalid}, 32'd0);
      chk("to_armreq_len", 32'(last_len), 32'(TO));
      force_ack = 1'b1;
      @(negedge clk);
      force_ack = 1'b0;
      @(negedge clk);
      chk("idle_ack_ignored", {29'd0, bvalid, rvalid, armreq}, 32'd0);
      run_txn(1'b0, 32'h0000_000C, 32'h0, 4'h0, resp, rd, lat);
      chk("post_to_rdata", rd, 32'h0000_0004);
      chk("post_to_lat", 32'(lat), 32'd3);

      // bvalid back-pressure blocks a pending read
      bready = 1'b0;
      run_txn(1'b1, 32'h0000_0014, 32'h0000_55AA, 4'hF, resp, rd, lat);
      chk("bp_bresp", {30'd0, resp}, 32'd0);
      araddr  = 32'h0000_0014;
      arvalid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk($sformatf("bp_hold%0d", i), {29'd0, bvalid, arready, armreq}, 32'd4);
      end
      bready  = 1'b1;
      arvalid = 1'b0;
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("bp_bvalid_drop", {31'd0, bvalid}, 32'd0);
      run_txn(1'b0, 32'h0000_0014, 32'h0, 4'h0, resp, rd, lat);
      chk("bp_read_rdata", rd, 32'h0000_55AA);

      // randomized traffic against the reference model
      for (int i = 0; i < 16; i++) begin
         v = $urandom;
         resp_mem[i]  = v;
         model_mem[i] = v;
      end
      for (int t = 0; t < 60; t++) begin
         logic [31:0] wd;
         logic [3:0]  strb;
         int          cls;
         wr   = ($urandom_range(0, 1) == 1);
         cls  = $urandom_range(0, 19);
         addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
         if (cls < 2) addr[9] = 1'b1;
         else if (cls < 5) addr[8] = 1'b1;
         wd      = $urandom;
         strb    = 4'($urandom_range(0, 15));
         ack_dly = $urandom_range(1, 4);
         model_txn(wr, addr, wd, strb, ack_dly, eresp, erd, elat);
         run_txn(wr, addr, wd, strb, resp, rd, lat);
         chk($sformatf("rnd%0d_resp", t), {30'd0, resp}, {30'd0, eresp});
         chk($sformatf("rnd%0d_lat", t), 32'(lat), 32'(elat));
         if (!wr) chk($sformatf("rnd%0d_rdata", t), rd, erd);
         chk($sformatf("rnd%0d_armaddr", t), mon_addr, addr);
         chk($sformatf("rnd%0d_armwdata", t), mon_wdata, wr ? wd : 32'h0);
      end
      chk("no_req_resp_overlap", 32'(overlap), 32'd0);

      // round-robin on simultaneous write and read, starting write-first after reset
      do_reset();
      ack_dly = 1;
      s0 = req_starts; b0 = n_bhs; r0 = n_rhs;
      @(posedge clk);
      #1;
      awaddr = 32'h0000_0020; wdata = 32'h0000_0011; wstrb = 4'hF;
      araddr = 32'h0000_000C;
      awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         n = 0;
         forever begin
            @(negedge clk);
            if (awready || arready) break;
            n++;
            if (n > 50) break;
         end
         got_wr = awready;
         chk($sformatf("rr_grant%0d_is_write", k), {31'd0, got_wr}, (k == 1) ? 32'd0 : 32'd1);
         chk($sformatf("rr_grant%0d_ready", k), {29'd0, awready, wready, arready}, (k == 1) ? 32'd1 : 32'd6);
         @(posedge clk);
         #1;
         if (k == 2) begin
            awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
         end
      end
      repeat (8) @(posedge clk);
      #1;
      chk("rr_req_count", 32'(req_starts - s0), 32'd3);
      chk("rr_bresp_count", 32'(n_bhs - b0), 32'd2);
      chk("rr_rresp_count", 32'(n_rhs - r0), 32'd1);

      // asynchronous reset in the middle of a request
      @(posedge clk);
      #1;
      awaddr = 32'h0000_0230; wdata = 32'h1; wstrb = 4'hF;
      awvalid = 1'b1; wvalid = 1'b1;
      n = 0;
      forever begin
         @(negedge clk);
         if (awready) break;
         n++;
         if (n > 50) break;
      end
      @(posedge clk);
      #1;
      awvalid = 1'b0; wvalid = 1'b0;
      repeat (3) @(negedge clk);
      chk("midreq_armreq", {31'd0, armreq}, 32'd1);
      #2;
      rstn = 1'b0;
      #1;
      chk("arst_ctrl", {22'd0, awready, wready, arready, bvalid, rvalid, armreq, armwr, armwstrb[0], bresp, rresp}, 32'd0);
      chk("arst_armaddr", armaddr, 32'h0);
      chk("arst_armwdata", armwdata | {28'd0, armwstrb}, 32'h0);
      @(posedge clk);
      #1;
      rstn = 1'b1;
      run_txn(1'b1, 32'h0000_0030, 32'hCAFE_F00D, 4'hF, resp, rd, lat);
      chk("post_rst_bresp", {30'd0, resp}, 32'd0);
      chk("post_rst_blat", 32'(lat), 32'd3);
      run_txn(1'b0, 32'h0000_0030, 32'h0, 4'h0, resp, rd, lat);
      chk("post_rst_rdata", rd, 32'hCAFE_F00D);
      chk("post_rst_rresp", {30'd0, resp}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
